// File: rtl/mux_rr_sched_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
package mux_sched_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [0:0] {IDLE, HOLD} sched_state_t;

  typedef logic [DATA_W-1:0] lane_t;

endpackage

// File: rtl/mux_rr_sched_if.sv
// Requester lanes plus downstream valid/ready bus of the mux scheduler.
interface mux_rr_sched_if #(
  parameter int unsigned CNT_W = 16
);

  logic [mux_sched_pkg::N_REQ-1:0]                             req;
  logic [mux_sched_pkg::N_REQ-1:0][mux_sched_pkg::DATA_W-1:0]  c_in;
  logic [mux_sched_pkg::SEL_W-1:0]                             select;
  mux_sched_pkg::lane_t                                        saida;
  logic                                                        saida_valid;
  logic                                                        saida_ready;
  logic [mux_sched_pkg::N_REQ-1:0]                             ack;
  logic                                                        busy;
  logic [CNT_W-1:0]                                            xfer_cnt;

  // Requesters and downstream consumer.
  modport master (
    output req, c_in, saida_ready,
    input  select, saida, saida_valid, ack, busy, xfer_cnt
  );

  // Scheduler.
  modport slave (
    input  req, c_in, saida_ready,
    output select, saida, saida_valid, ack, busy, xfer_cnt
  );

endinterface

// File: rtl/mux_rr_sched_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_picker
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // rot[i] is the request i places after ptr; truncation to SEL_W gives the wrap.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req_i[SEL_W'(i + int'(ptr_i))];
    end
  end

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign found_o = |req_i;
  assign idx_o   = ptr_i + off;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for a shared 8-way byte mux with valid/ready output.
// Define MUX_SCHED_PRIO0_EN to give requester 0 absolute priority in IDLE.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  mux_rr_sched_if.slave bus
);

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  lane_t            saida_q, saida_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] win_idx;

  rr_picker u_picker (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef MUX_SCHED_PRIO0_EN
  assign win_idx = bus.req[0] ? '0 : pick_idx;
`else
  assign win_idx = pick_idx;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    saida_d = saida_q;
    ack_d   = '0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = win_idx;
          saida_d = bus.c_in[win_idx];
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.saida_ready) begin
          ack_d   = N_REQ'(1) << sel_q;
          ptr_d   = sel_q + SEL_W'(1);
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      saida_q <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      saida_q <= saida_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.select      = sel_q;
  assign bus.saida       = saida_q;
  assign bus.saida_valid = (state_q == HOLD);
  assign bus.busy        = (state_q == HOLD);
  assign bus.ack         = ack_q;
  assign bus.xfer_cnt    = cnt_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: transaction-level model plus directed checks.
module tb_mux_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_rr_sched_if #(.CNT_W(16)) bus ();

  mux_rr_sched #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int idx_of(input logic [7:0] a);
    int r = -1;
    for (int i = 0; i < 8; i++) if (a[i]) r = i;
    return r;
  endfunction

  // Model: one pending byte at most; on handshake the ack goes out the next cycle.
  bit         m_valid;
  int         m_sel;
  logic [7:0] m_data;
  logic [7:0] m_ack;
  int         m_cnt;
  int         m_ptr;

  function automatic int model_winner(input logic [7:0] r, input int p);
    int w = -1;
`ifdef MUX_SCHED_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 7; k >= 0; k--) if (r[(p + k) % 8]) w = (p + k) % 8;
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_sel = 0; m_data = 8'h00; m_ack = 8'h00; m_cnt = 0; m_ptr = 0;
    end else begin
      m_ack = 8'h00;
      if (!m_valid) begin
        if (bus.req != 8'h00) begin
          m_sel   = model_winner(bus.req, m_ptr);
          m_data  = bus.c_in[m_sel];
          m_valid = 1;
        end
      end else if (bus.saida_ready) begin
        m_ack   = 8'h01 << m_sel;
        m_valid = 0;
        m_ptr   = (m_sel + 1) % 8;
        if (m_cnt != 65535) m_cnt++;
      end
    end
  end

  int grants[$];
  int gtimes[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    chk("select", bus.select, m_sel);
    chk("saida", bus.saida, m_data);
    chk("saida_valid", bus.saida_valid, m_valid);
    chk("busy", bus.busy, m_valid);
    chk("ack", bus.ack, m_ack);
    chk("xfer_cnt", bus.xfer_cnt, m_cnt);
    if (!rst && bus.ack != 8'h00) begin
      chk("ack_onehot", $onehot(bus.ack), 1);
      grants.push_back(idx_of(bus.ack));
      gtimes.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_grants(input string name, input int exp[$], input bit spaced);
    chk({name, "_count"}, grants.size(), exp.size());
    for (int k = 0; k < exp.size() && k < grants.size(); k++) begin
      chk({name, "_lane"}, grants[k], exp[k]);
      if (spaced && k > 0) chk({name, "_spacing"}, gtimes[k] - gtimes[k-1], 2);
    end
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  int exp_q[$];

  initial begin
    bus.req = 8'h00;
    bus.c_in = '0;
    bus.saida_ready = 1'b0;
    #12 rst = 1'b0;

    // Idle with no requests.
    step(10);
    chk("idle_valid", bus.saida_valid, 0);
    chk("idle_select", bus.select, 0);
    chk("idle_cnt", bus.xfer_cnt, 0);

    // Single transfer from lane 0.
    bus.c_in[0] = 8'hA5;
    bus.saida_ready = 1'b1;
    bus.req = 8'h01;
    step(1);
    chk("t1_valid", bus.saida_valid, 1);
    chk("t1_saida", bus.saida, 8'hA5);
    chk("t1_select", bus.select, 0);
    bus.req = 8'h00;
    step(1);
    chk("t1_ack", bus.ack, 8'h01);
    chk("t1_cnt", bus.xfer_cnt, 1);
    step(1);
    chk("t1_ack_clear", bus.ack, 8'h00);

    // Lane 3 held under backpressure while its inputs change.
    bus.saida_ready = 1'b0;
    bus.c_in[3] = 8'h3C;
    bus.req = 8'h08;
    step(1);
    chk("t3_select", bus.select, 3);
    bus.c_in[3] = 8'hFF;
    bus.req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t3_hold_saida", bus.saida, 8'h3C);
      chk("t3_hold_valid", bus.saida_valid, 1);
    end
    bus.saida_ready = 1'b1;
    step(1);
    chk("t3_ack", bus.ack, 8'h08);
    chk("t3_cnt", bus.xfer_cnt, 2);

    // Asynchronous reset in the middle of HOLD.
    bus.saida_ready = 1'b0;
    bus.c_in[2] = 8'h5A;
    bus.req = 8'h04;
    step(1);
    chk("r_pre_valid", bus.saida_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("r_select", bus.select, 0);
    chk("r_saida", bus.saida, 0);
    chk("r_valid", bus.saida_valid, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_cnt", bus.xfer_cnt, 0);
    bus.req = 8'h00;
    bus.saida_ready = 1'b1;
    step(1);
    chk("r_no_ack", bus.ack, 8'h00);
    rst = 1'b0;
    step(1);

    // All lanes requesting, scan restarts from 0 after reset.
    grants.delete();
    gtimes.delete();
    for (int i = 0; i < 8; i++) bus.c_in[i] = 8'(i * 17);
    bus.req = 8'hFF;
    step(18);
    bus.req = 8'h00;
    step(2);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    check_grants("rr_all", exp_q, 1'b1);
    chk("rr_cnt", bus.xfer_cnt, 9);

    // Lanes 0 and 7 competing.
    pulse_reset();
    grants.delete();
    gtimes.delete();
    bus.saida_ready = 1'b1;
    bus.req = 8'h81;
    step(8);
    bus.req = 8'h00;
    step(2);
`ifdef MUX_SCHED_PRIO0_EN
    exp_q = '{0, 0, 0, 0};
`else
    exp_q = '{0, 7, 0, 7};
`endif
    check_grants("pair", exp_q, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
